// File: rtl/rf_pkg.sv
// Shared register-file constants and types for the write-port arbiter slice.
// Pure definitions; no logic, no latency, no backpressure.
package rf_pkg;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  localparam reg_addr_t ZERO_REG = 5'd31;
endpackage

// File: rtl/decoder5x32.sv
// 5-to-32 one-hot decoder with enable; output is all-zero when disabled.
// Combinational, 0 cycles; no backpressure.
module decoder5x32
  import rf_pkg::*;
(
  input  logic                en,
  input  reg_addr_t           addr,
  output logic [NUM_REGS-1:0] dec
);

  always_comb begin
    dec = '0;
    if (en) dec[addr] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin search starting at ptr, wrapping modulo N; first request wins.
// Combinational, 0 cycles; en low suppresses every grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner,
  output logic          any
);

  logic [IW-1:0] idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (en && !any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
    if (any) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port among NUM_REQ producers by round-robin.
// Latency 1: handshake at edge N, wr_* valid in cycle N+1; rf_stall or reset holds all req_ready low.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  reg_addr_t [NUM_REQ-1:0]         req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            rf_stall,
  output logic [NUM_REGS-1:0]             wr_en,
  output reg_addr_t                       wr_addr,
  output logic [DATA_W-1:0]               wr_data,
  output logic [IW-1:0]                   grant_id,
  output logic [15:0]                     drop_cnt
);

  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       winner;
  logic                any_grant;
  logic                dec_en;
  reg_addr_t           sel_addr;
  logic [NUM_REGS-1:0] dec;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .en     (reset_n & ~rf_stall),
    .grant  (req_ready),
    .winner (winner),
    .any    (any_grant)
  );

  assign sel_addr = req_addr[winner];
  // X31 completes the handshake but never reaches the register file.
  assign dec_en   = any_grant && (sel_addr != ZERO_REG);

  decoder5x32 u_dec (
    .en   (dec_en),
    .addr (sel_addr),
    .dec  (dec)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr   <= '0;
      wr_en    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      grant_id <= '0;
      drop_cnt <= '0;
    end else begin
      wr_en <= dec;
      if (any_grant) begin
        rr_ptr   <= (winner == IW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
        wr_addr  <= sel_addr;
        wr_data  <= req_data[winner];
        grant_id <= winner;
        if (!dec_en && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, single write, X31 drop, fairness, stall, mid-stream reset.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [3:0]           req_valid;
  reg_addr_t [3:0]      req_addr;
  logic [3:0][63:0]     req_data;
  logic [3:0]           req_ready;
  logic                 rf_stall;
  logic [31:0]          wr_en;
  reg_addr_t            wr_addr;
  logic [63:0]          wr_data;
  logic [1:0]           grant_id;
  logic [15:0]          drop_cnt;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  rf_write_arbiter #(.NUM_REQ(4), .DATA_W(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_stall  (rf_stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed and outputs sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    rf_stall  = 1'b0;
    req_valid = 4'hF;
    req_addr  = '0;
    req_data  = '0;

    // Reset with every requester valid: no grants, outputs cleared.
    tick();
    chk("rst_ready_c0", req_ready, 4'b0000);
    tick();
    chk("rst_ready_c1", req_ready, 4'b0000);
    chk("rst_wr_en", wr_en, 32'h0);
    chk("rst_wr_addr", wr_addr, 5'd0);
    chk("rst_wr_data", wr_data, 64'h0);
    chk("rst_grant_id", grant_id, 2'd0);
    chk("rst_drop_cnt", drop_cnt, 16'd0);

    // Release with no requests: stays idle.
    reset_n   = 1'b1;
    req_valid = 4'b0000;
    #1 chk("idle_ready", req_ready, 4'b0000);
    tick();
    chk("idle_wr_en", wr_en, 32'h0);
    chk("idle_wr_data", wr_data, 64'h0);

    // Single write from requester 1.
    req_valid   = 4'b0010;
    req_addr[1] = 5'd5;
    req_data[1] = 64'hDEAD;
    #1 chk("single_ready", req_ready, 4'b0010);
    tick();
    chk("single_wr_en", wr_en, 32'h0000_0020);
    chk("single_wr_addr", wr_addr, 5'd5);
    chk("single_wr_data", wr_data, 64'hDEAD);
    chk("single_grant_id", grant_id, 2'd1);

    // Pointer is now 2: requester 2 writes X31 while everyone is valid.
    req_valid = 4'hF;
    req_addr[0] = 5'd1; req_addr[1] = 5'd2; req_addr[2] = 5'd31; req_addr[3] = 5'd4;
    for (int i = 0; i < 4; i++) req_data[i] = 64'h100 + 64'(i);
    #1 chk("zero_ready", req_ready, 4'b0100);
    tick();
    chk("zero_wr_en", wr_en, 32'h0);
    chk("zero_wr_addr", wr_addr, 5'd31);
    chk("zero_grant_id", grant_id, 2'd2);
    chk("zero_drop_cnt", drop_cnt, 16'd1);
    chk("zero_next_ready", req_ready, 4'b1000);
    req_addr[2] = 5'd3;
    tick();
    chk("after_zero_wr_en", wr_en, 32'h0000_0010);
    chk("after_zero_grant_id", grant_id, 2'd3);
    chk("after_zero_wr_data", wr_data, 64'h103);
    chk("after_zero_drop_cnt", drop_cnt, 16'd1);

    // Fairness: all valid, addrs 1..4, pointer back at 0.
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("fair_ready_%0d", k), req_ready, 64'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("fair_wr_en_%0d", k), wr_en, 64'(32'h2 << (k % 4)));
      chk($sformatf("fair_gid_%0d", k), grant_id, 64'(k % 4));
    end

    // Stall for 3 cycles: pointer held at 1.
    rf_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("stall_ready_%0d", k), req_ready, 4'b0000);
      tick();
      chk($sformatf("stall_wr_en_%0d", k), wr_en, 32'h0);
    end
    rf_stall = 1'b0;
    #1 chk("unstall_ready", req_ready, 4'b0010);
    tick();
    chk("unstall_wr_en", wr_en, 32'h0000_0004);
    chk("unstall_gid", grant_id, 2'd1);
    chk("b2b_ready", req_ready, 4'b0100);
    tick();
    chk("b2b_wr_en", wr_en, 32'h0000_0008);

    // Reset in the middle of back-to-back grants.
    reset_n = 1'b0;
    #1 chk("midrst_ready", req_ready, 4'b0000);
    tick();
    chk("midrst_wr_en", wr_en, 32'h0);
    chk("midrst_ptr", dut.rr_ptr, 2'd0);
    chk("midrst_drop_cnt", drop_cnt, 16'd0);
    chk("midrst_gid", grant_id, 2'd0);
    reset_n = 1'b1;
    #1 chk("postrst_ready", req_ready, 4'b0001);
    tick();
    chk("postrst_wr_en", wr_en, 32'h0000_0002);
    chk("postrst_gid", grant_id, 2'd0);

    // Wrap-around: pointer is 1, only requester 0 valid.
    req_valid = 4'b0001;
    #1 chk("wrap_ready", req_ready, 4'b0001);
    tick();
    chk("wrap_wr_en", wr_en, 32'h0000_0002);
    req_valid = 4'b0000;
    tick();
    chk("final_idle_wr_en", wr_en, 32'h0);
    chk("final_hold_addr", wr_addr, 5'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
